shader_scheduler: RTL and testbench

Frame-level controller for the pixel-shader array. It broadcasts a voxel stream to every shader, sequences the rasterize and shade phases with do_rasterize/do_shade, and waits on the array-wide done signals. It then scans the shared pixel bus by row/col and streams the pixels to the framebuffer writer. It sits between the voxel buffer (upstream) and the framebuffer (downstream), with the shader array on the side.

---
 rtl/shader_scheduler.sv | 122 ++++++++++++
 tb/tb_shader_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_scheduler.sv
// shader_scheduler: frame controller that feeds voxels to the shader array, sequences rasterize/shade, and streams pixels to the framebuffer
module shader_scheduler #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int CNT_BITS     = 16,
  parameter int TIMEOUT      = 1023
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [CNT_BITS-1:0]          voxel_count,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [COORD_BITS-1:0]        in_x,
  input  logic [COORD_BITS-1:0]        in_y,
  input  logic [COORD_BITS-1:0]        in_z,
  input  logic [PALETTE_BITS-1:0]      in_id,
  output logic [COORD_BITS-1:0]        voxel_x,
  output logic [COORD_BITS-1:0]        voxel_y,
  output logic [COORD_BITS-1:0]        voxel_z,
  output logic [PALETTE_BITS-1:0]      voxel_id,
  output logic                         do_rasterize,
  output logic                         do_shade,
  input  logic                         rast_done_all,
  input  logic                         shade_done_all,
  output logic [ROW_BITS-1:0]          row,
  output logic [COL_BITS-1:0]          col,
  input  logic [PIXEL_BITS-1:0]        pixel,
  output logic                         fb_valid,
  input  logic                         fb_ready,
  output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
  output logic [PIXEL_BITS-1:0]        fb_data,
  output logic                         frame_done,
  output logic                         error
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] RASTER  = 3'd2;
  localparam logic [2:0] SHADE   = 3'd3;
  localparam logic [2:0] READOUT = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;
  localparam int WD_BITS   = $clog2(TIMEOUT + 1);
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  logic [2:0]          state;
  logic [CNT_BITS-1:0] remaining;
  logic [WD_BITS-1:0]  wdog;
  logic                load, timeout, last_col, last_row;

  // A voxel is accepted in FETCH, or in RASTER once the array finished the previous one and more remain
  assign in_ready     = state == FETCH || (state == RASTER && rast_done_all && remaining != '0);
  assign load         = in_valid && in_ready;
  assign timeout      = wdog == WD_BITS'(TIMEOUT - 1);
  assign last_col     = col == COL_BITS'(COLS - 1);
  assign last_row     = row == ROW_BITS'(ROWS - 1);
  assign do_rasterize = state == RASTER;
  assign do_shade     = state == SHADE;
  assign fb_valid     = state == READOUT;
  assign frame_done   = state == FINISH;
  assign fb_data      = pixel;
  assign fb_addr      = ADDR_BITS'(row) * ADDR_BITS'(COLS) + ADDR_BITS'(col);

  // Capture each accepted voxel for broadcast; held stable until the next accept
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {voxel_x, voxel_y, voxel_z, voxel_id} <= '0;
    else if (load) {voxel_x, voxel_y, voxel_z, voxel_id} <= {in_x, in_y, in_z, in_id};

  // Frame sequencer with a watchdog that aborts a stalled rasterize/shade wait
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      wdog      <= '0;
      row       <= '0;
      col       <= '0;
      error     <= 1'b0;
    end else begin
      if (load) remaining <= remaining - CNT_BITS'(1);
      case (state)
        IDLE: if (start) begin
          remaining <= voxel_count;
          error     <= 1'b0;
          wdog      <= '0;
          state     <= voxel_count == '0 ? SHADE : FETCH;
        end
        FETCH: if (in_valid) begin
          wdog  <= '0;
          state <= RASTER;
        end
        RASTER: if (rast_done_all) begin
          wdog  <= '0;
          state <= remaining == '0 ? SHADE : in_valid ? RASTER : FETCH;
        end else if (timeout) begin
          wdog  <= '0;
          error <= 1'b1;
          state <= IDLE;
        end else wdog <= wdog + WD_BITS'(1);
        SHADE: if (shade_done_all) begin
          wdog  <= '0;
          row   <= '0;
          col   <= '0;
          state <= READOUT;
        end else if (timeout) begin
          wdog  <= '0;
          error <= 1'b1;
          state <= IDLE;
        end else wdog <= wdog + WD_BITS'(1);
        READOUT: if (fb_ready) begin
          col <= last_col ? '0 : col + COL_BITS'(1);
          if (last_col) row <= last_row ? '0 : row + ROW_BITS'(1);
          if (last_col && last_row) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shader_scheduler.sv
// tb_shader_scheduler: directed scenarios for the shader frame scheduler with a small shader-array model
module tb_shader_scheduler;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] voxel_count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x, in_y, in_z, in_id;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
  logic        do_rasterize, do_shade;
  logic        rast_done_all = 1'b0;
  logic        shade_done_all = 1'b0;
  logic [7:0]  row, col, pixel, fb_data;
  logic        fb_valid, frame_done, error;
  logic        fb_ready = 1'b1;
  logic [15:0] fb_addr;

  int total = 0;
  int bad = 0;

  int vidx, nl, n_wr, n_done, n_rise, n_fall, n_rhi, n_stall, hold_bad, rc, sc, pc;
  logic [7:0]  lx[8], ly[8], lz[8], lid[8];
  logic [15:0] wa[64];
  logic [7:0]  wd[64];
  logic [7:0]  prow, pcol;
  logic [3:0]  pat = 4'b1001;
  bit pend_load, prev_rast, prev_stall;
  bit auto_rast = 1'b1;
  bit stall_mode = 1'b0;

  always #5 clock = ~clock;

  assign in_x  = 8'(vidx * 3 + 1);
  assign in_y  = 8'(vidx * 3 + 2);
  assign in_z  = 8'(vidx * 3 + 3);
  assign in_id = 8'(vidx + 64);
  assign pixel = {row[3:0], col[3:0]};

  shader_scheduler #(.TIMEOUT(20)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .voxel_count(voxel_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_id(in_id),
    .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
    .do_rasterize(do_rasterize), .do_shade(do_shade),
    .rast_done_all(rast_done_all), .shade_done_all(shade_done_all),
    .row(row), .col(col), .pixel(pixel),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .error(error)
  );

  // Shader-array model and monitor: drive inputs at negedge, sample settled outputs 1ns later
  always @(negedge clock) begin
    if (pend_load) begin
      if (nl < 8) begin
        lx[nl] = voxel_x; ly[nl] = voxel_y; lz[nl] = voxel_z; lid[nl] = voxel_id;
      end
      nl++;
      vidx++;
    end
    rc = pend_load ? 0 : do_rasterize ? rc + 1 : 0;
    sc = do_shade ? sc + 1 : 0;
    rast_done_all = auto_rast && do_rasterize && rc >= 2;
    shade_done_all = do_shade && sc >= 3;
    if (fb_valid) begin
      fb_ready = stall_mode ? pat[pc % 4] : 1'b1;
      pc++;
    end else fb_ready = 1'b1;
    #1;
    if (prev_stall && (row !== prow || col !== pcol)) hold_bad++;
    prev_stall = fb_valid && !fb_ready;
    prow = row;
    pcol = col;
    if (prev_stall) n_stall++;
    if (fb_valid && fb_ready) begin
      if (n_wr < 64) begin wa[n_wr] = fb_addr; wd[n_wr] = fb_data; end
      n_wr++;
    end
    if (frame_done) n_done++;
    if (do_rasterize) n_rhi++;
    if (do_rasterize && !prev_rast) n_rise++;
    if (!do_rasterize && prev_rast) n_fall++;
    prev_rast = do_rasterize;
    pend_load = in_valid && in_ready;
  end

  task automatic clear_mon();
    nl = 0; n_wr = 0; n_done = 0; n_rise = 0; n_fall = 0; n_rhi = 0;
    n_stall = 0; hold_bad = 0; pc = 0; vidx = 0; prev_rast = 0; prev_stall = 0;
  endtask

  task automatic start_frame(input logic [15:0] cnt);
    @(posedge clock); #1;
    voxel_count = cnt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clock); #2;
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    ctl = {in_ready, do_rasterize, do_shade, fb_valid, frame_done, error};
    total++; if (ctl !== 6'b0) begin bad++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
    total++; if ({voxel_x, voxel_y, voxel_z, voxel_id} !== 32'h0) begin bad++; $display("FAIL reset_voxel: got %h expected 0", {voxel_x, voxel_y, voxel_z, voxel_id}); end
    total++; if ({row, col, fb_addr} !== 32'h0) begin bad++; $display("FAIL reset_rowcol: got %h expected 0", {row, col, fb_addr}); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    total++; if ({in_ready, do_rasterize, fb_valid} !== 3'b0) begin bad++; $display("FAIL idle_after_reset: got %b expected 000", {in_ready, do_rasterize, fb_valid}); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd3);
    wait_frame(300, ok);
    in_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL b2b_frame_done: got none expected pulse"); end
    total++; if (nl !== 3) begin bad++; $display("FAIL b2b_loads: got %0d expected 3", nl); end
    for (int i = 0; i < 3; i++) begin
      total++; if (lx[i] !== 8'(i * 3 + 1) || lid[i] !== 8'(i + 64)) begin bad++; $display("FAIL b2b_voxel%0d: got x=%0d id=%0d expected x=%0d id=%0d", i, lx[i], lid[i], i * 3 + 1, i + 64); end
    end
    total++; if (n_rise !== 1 || n_fall !== 1) begin bad++; $display("FAIL b2b_rast_continuous: got rises=%0d falls=%0d expected 1 1", n_rise, n_fall); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL b2b_writes: got %0d expected 16", n_wr); end
    for (int i = 0; i < 16; i++) begin
      total++; if (wa[i] !== 16'(i) || wd[i] !== 8'((i / 4) * 16 + i % 4)) begin bad++; $display("FAIL b2b_wr%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wa[i], wd[i], i, 8'((i / 4) * 16 + i % 4)); end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_fetch_wait();
    bit ok, seen;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #2;
      seen = do_rasterize;
    end
    in_valid = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL fw_first_load: got no do_rasterize expected 1"); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #2;
      seen = rast_done_all;
    end
    total++; if (!seen) begin bad++; $display("FAIL fw_rast_done: got none expected done"); end
    repeat (4) @(posedge clock);
    #2;
    total++; if (do_rasterize !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fw_waiting: got rast=%b ready=%b expected 0 1", do_rasterize, in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b1;
    wait_frame(300, ok);
    in_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL fw_frame_done: got none expected pulse"); end
    total++; if (nl !== 2) begin bad++; $display("FAIL fw_loads: got %0d expected 2", nl); end
    total++; if ({lx[1], ly[1], lz[1], lid[1]} !== {8'd4, 8'd5, 8'd6, 8'd65}) begin bad++; $display("FAIL fw_voxel2: got %h expected 04050641", {lx[1], ly[1], lz[1], lid[1]}); end
    total++; if (n_rise !== 2) begin bad++; $display("FAIL fw_rast_rises: got %0d expected 2", n_rise); end
    total++; if (n_wr !== 16 || n_done !== 1) begin bad++; $display("FAIL fw_readout: got writes=%0d done=%0d expected 16 1", n_wr, n_done); end
  endtask

  task automatic test_zero_voxels();
    bit ok;
    clear_mon();
    start_frame(16'd0);
    wait_frame(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_frame_done: got none expected pulse"); end
    total++; if (n_rhi !== 0 || nl !== 0) begin bad++; $display("FAIL zero_no_raster: got rast_cycles=%0d loads=%0d expected 0 0", n_rhi, nl); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL zero_writes: got %0d expected 16", n_wr); end
    for (int i = 0; i < 16; i++) begin
      total++; if (wa[i] !== 16'(i)) begin bad++; $display("FAIL zero_addr%0d: got %0d expected %0d", i, wa[i], i); end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_fb_stall();
    bit ok;
    clear_mon();
    stall_mode = 1'b1;
    in_valid = 1'b1;
    start_frame(16'd1);
    wait_frame(400, ok);
    in_valid = 1'b0;
    stall_mode = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL stall_frame_done: got none expected pulse"); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL stall_writes: got %0d expected 16", n_wr); end
    for (int i = 0; i < 16; i++) begin
      total++; if (wa[i] !== 16'(i) || wd[i] !== 8'((i / 4) * 16 + i % 4)) begin bad++; $display("FAIL stall_wr%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wa[i], wd[i], i, 8'((i / 4) * 16 + i % 4)); end
    end
    total++; if (n_stall !== 16) begin bad++; $display("FAIL stall_cycles: got %0d expected 16", n_stall); end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d moves expected 0", hold_bad); end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    auto_rast = 1'b0;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #2;
      seen = error;
    end
    in_valid = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL to_error: got 0 expected 1"); end
    total++; if (n_rhi !== 20) begin bad++; $display("FAIL to_raster_cycles: got %0d expected 20", n_rhi); end
    total++; if ({do_rasterize, do_shade, in_ready, fb_valid} !== 4'b0) begin bad++; $display("FAIL to_idle: got %b expected 0000", {do_rasterize, do_shade, in_ready, fb_valid}); end
    repeat (4) @(posedge clock);
    #2;
    total++; if (n_done !== 0 || error !== 1'b1) begin bad++; $display("FAIL to_no_done: got done=%0d err=%b expected 0 1", n_done, error); end
    auto_rast = 1'b1;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd1);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL to_start_clears: got %b expected 0", error); end
    wait_frame(300, ok);
    in_valid = 1'b0;
    total++; if (!ok || n_done !== 1 || n_wr !== 16) begin bad++; $display("FAIL to_recover: got done=%0d writes=%0d expected 1 16", n_done, n_wr); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #2;
      seen = n_wr >= 5;
    end
    total++; if (!seen || fb_valid !== 1'b1) begin bad++; $display("FAIL rm_in_readout: got valid=%b writes=%0d expected 1 >=5", fb_valid, n_wr); end
    #1;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if ({in_ready, do_rasterize, do_shade, fb_valid, frame_done, error} !== 6'b0) begin bad++; $display("FAIL rm_ctl: got %b expected 000000", {in_ready, do_rasterize, do_shade, fb_valid, frame_done, error}); end
    total++; if ({voxel_x, voxel_y, voxel_z, voxel_id} !== 32'h0 || {row, col, fb_addr} !== 32'h0) begin bad++; $display("FAIL rm_regs: got voxel=%h rowcol=%h expected 0 0", {voxel_x, voxel_y, voxel_z, voxel_id}, {row, col, fb_addr}); end
    repeat (3) @(posedge clock);
    #2;
    total++; if (n_done !== 0) begin bad++; $display("FAIL rm_no_done: got %0d expected 0", n_done); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_mon();
    in_valid = 1'b1;
    start_frame(16'd2);
    wait_frame(300, ok);
    in_valid = 1'b0;
    total++; if (!ok || n_done !== 1 || nl !== 2) begin bad++; $display("FAIL rm_rerun: got done=%0d loads=%0d expected 1 2", n_done, nl); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL rm_rerun_writes: got %0d expected 16", n_wr); end
    for (int i = 0; i < 16; i++) begin
      total++; if (wa[i] !== 16'(i) || wd[i] !== 8'((i / 4) * 16 + i % 4)) begin bad++; $display("FAIL rm_wr%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wa[i], wd[i], i, 8'((i / 4) * 16 + i % 4)); end
    end
  endtask

  initial begin
    clear_mon();
    pend_load = 1'b0;
    rc = 0;
    sc = 0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_back_to_back();
    test_fetch_wait();
    test_zero_voxels();
    test_fb_stall();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation did not complete");
  end
endmodule
